// File: rtl/serial_tx_arb.sv
// Round-robin arbiter that feeds bytes from NUM_REQ requesters to one serial transmitter.
// A grant stays locked for a whole packet. It is released early on a lock timeout or a missing ack.
module serial_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           ser_data_out,
    output logic                 ser_out_en,
    input  logic                 ser_out_rdy,
    output logic [2:0]           grant_id,
    output logic                 grant_valid,
    output logic                 lock_timeout,
    output logic                 ser_err
);

    localparam int LCW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {ARB, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state, state_n;
    logic [2:0]         last_grant, last_grant_n;
    logic [2:0]         grant_id_n;
    logic               grant_valid_n;
    logic [7:0]         data_n;
    logic               en_n;
    logic [NUM_REQ-1:0] ready_n;
    logic               to_n, err_n;
    logic [LCW-1:0]     lock_cnt, lock_cnt_n;
    logic [1:0]         busy_cnt, busy_cnt_n;
    logic               last_q, last_q_n;

    // Requester lanes widened to 8 so that a 3-bit grant index never goes out of range.
    logic [7:0] valid8, last8;
    logic [7:0] data8 [8];

    for (genvar i = 0; i < 8; i++) begin : g_lane
        if (i < NUM_REQ) begin : g_on
            assign valid8[i] = req_valid[i];
            assign last8[i]  = req_last[i];
            assign data8[i]  = req_data[8*i +: 8];
        end else begin : g_off
            assign valid8[i] = 1'b0;
            assign last8[i]  = 1'b0;
            assign data8[i]  = 8'h00;
        end
    end

    // Round-robin pick. The loop runs from the farthest offset down to the nearest, so the nearest valid requester wins.
    logic [2:0] pick;
    logic       pick_ok;
    logic [3:0] rr_idx;

    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        rr_idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = {1'b0, last_grant} + 4'(k);
            if (rr_idx >= 4'(NUM_REQ))
                rr_idx = rr_idx - 4'(NUM_REQ);
            if (valid8[rr_idx[2:0]]) begin
                pick    = rr_idx[2:0];
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        grant_id_n    = grant_id;
        grant_valid_n = grant_valid;
        last_grant_n  = last_grant;
        data_n        = ser_data_out;
        en_n          = 1'b0;
        ready_n       = '0;
        to_n          = 1'b0;
        err_n         = 1'b0;
        lock_cnt_n    = lock_cnt;
        busy_cnt_n    = busy_cnt;
        last_q_n      = last_q;
        case (state)
            ARB: begin
                grant_valid_n = 1'b0;
                lock_cnt_n    = '0;
                if (pick_ok) begin
                    grant_id_n    = pick;
                    grant_valid_n = 1'b1;
                    state_n       = SEND;
                end
            end
            SEND: begin
                if (valid8[grant_id]) begin
                    lock_cnt_n = '0;
                    if (ser_out_rdy) begin
                        data_n   = data8[grant_id];
                        en_n     = 1'b1;
                        last_q_n = last8[grant_id];
                        for (int i = 0; i < NUM_REQ; i++)
                            ready_n[i] = (grant_id == 3'(i));
                        busy_cnt_n = '0;
                        state_n    = WAIT_BUSY;
                    end
                end else if (lock_cnt == LCW'(LOCK_TIMEOUT - 1)) begin
                    to_n          = 1'b1;
                    grant_valid_n = 1'b0;
                    last_grant_n  = grant_id;
                    lock_cnt_n    = '0;
                    state_n       = ARB;
                end else begin
                    lock_cnt_n = lock_cnt + LCW'(1);
                end
            end
            WAIT_BUSY: begin
                if (!ser_out_rdy) begin
                    state_n = WAIT_DONE;
                end else if (busy_cnt == 2'd3) begin
                    // The controller never took the strobe, so give up on this grant.
                    err_n         = 1'b1;
                    grant_valid_n = 1'b0;
                    last_grant_n  = grant_id;
                    state_n       = ARB;
                end else begin
                    busy_cnt_n = busy_cnt + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (ser_out_rdy) begin
                    if (last_q) begin
                        grant_valid_n = 1'b0;
                        last_grant_n  = grant_id;
                        state_n       = ARB;
                    end else begin
                        state_n = SEND;
                    end
                end
            end
            default: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB;
            last_grant   <= 3'(NUM_REQ - 1);
            grant_id     <= '0;
            grant_valid  <= 1'b0;
            ser_data_out <= '0;
            ser_out_en   <= 1'b0;
            req_ready    <= '0;
            lock_timeout <= 1'b0;
            ser_err      <= 1'b0;
            lock_cnt     <= '0;
            busy_cnt     <= '0;
            last_q       <= 1'b0;
        end else begin
            state        <= state_n;
            last_grant   <= last_grant_n;
            grant_id     <= grant_id_n;
            grant_valid  <= grant_valid_n;
            ser_data_out <= data_n;
            ser_out_en   <= en_n;
            req_ready    <= ready_n;
            lock_timeout <= to_n;
            ser_err      <= err_n;
            lock_cnt     <= lock_cnt_n;
            busy_cnt     <= busy_cnt_n;
            last_q       <= last_q_n;
        end
    end

endmodule

// File: tb/tb_serial_tx_arb.sv
// Directed bench for serial_tx_arb. It models the requester FIFOs and a simple serial controller on the falling edge.
module tb_serial_tx_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  ser_data_out;
    logic        ser_out_en;
    logic        ser_out_rdy = 1'b1;
    logic [2:0]  grant_id;
    logic        grant_valid;
    logic        lock_timeout;
    logic        ser_err;

    serial_tx_arb #(.NUM_REQ(4), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .ser_data_out(ser_data_out), .ser_out_en(ser_out_en), .ser_out_rdy(ser_out_rdy),
        .grant_id(grant_id), .grant_valid(grant_valid),
        .lock_timeout(lock_timeout), .ser_err(ser_err)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int cyc = 0, busy = 0, bad = 0;
    bit noack = 1'b0, prev_en = 1'b0;
    logic [8:0] mem [4][16];
    int head [4] = '{0, 0, 0, 0};
    int tail [4] = '{0, 0, 0, 0};
    logic [7:0] out_log [64];
    logic [2:0] gid_log [64];
    int n_out = 0, n_to = 0, n_err = 0;
    int to_delta = 0, err_delta = 0, strobe_cyc = 0, rise_cyc = 0;
    int rdy_cnt [4] = '{0, 0, 0, 0};
    logic [3:0] exp_rdy;

    // Monitor, serial controller model and requester FIFOs, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        exp_rdy = '0;
        for (int i = 0; i < 4; i++)
            if (grant_id == 3'(i)) exp_rdy[i] = 1'b1;
        if (ser_out_en) begin
            if (n_out < 64) begin
                out_log[n_out] = ser_data_out;
                gid_log[n_out] = grant_id;
            end
            n_out++;
            strobe_cyc = cyc;
            if (prev_en || req_ready != exp_rdy) bad++;
        end else if (req_ready != 4'b0) begin
            bad++;
        end
        prev_en = ser_out_en;
        for (int i = 0; i < 4; i++)
            if (req_ready[i]) rdy_cnt[i]++;
        if (lock_timeout) begin n_to++; to_delta = cyc - rise_cyc; end
        if (ser_err) begin n_err++; err_delta = cyc - strobe_cyc; end

        if (noack) begin
            ser_out_rdy = 1'b1;
            busy = 0;
        end else if (ser_out_en) begin
            ser_out_rdy = 1'b0;
            busy = 3;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin ser_out_rdy = 1'b1; rise_cyc = cyc; end
        end

        for (int i = 0; i < 4; i++)
            if (req_ready[i] && head[i] < tail[i]) head[i]++;
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = mem[i][head[i]][7:0];
                req_last[i]        = mem[i][head[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        mem[r][tail[r]] = {last, d};
        tail[r]++;
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < 4; i++)
            if (head[i] != tail[i]) e = 1'b0;
        return e;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (n < budget && !(all_empty() && !grant_valid && ser_out_rdy && !ser_out_en)) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n < budget), 1);
        tick(2);
    endtask

    task automatic wait_out(input string tag, input int target, input int budget);
        int n = 0;
        while (n_out < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, n_out, target);
    endtask

    int base, r2;

    initial begin
        tick(3);
        chk("rst_en", ser_out_en, 0);
        chk("rst_data", ser_data_out, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_gv", grant_valid, 0);
        chk("rst_to", lock_timeout, 0);
        chk("rst_err", ser_err, 0);
        rst = 1'b0;
        tick(2);

        // Contention: all four requesters, two rounds. Requester 0 goes first after reset.
        for (int i = 0; i < 4; i++) push(i, 1'b1, 8'(8'h10 + i));
        drain("drain_rr1", 200);
        for (int i = 0; i < 4; i++) push(i, 1'b1, 8'(8'h10 + i));
        drain("drain_rr2", 200);
        chk("rr_count", n_out, 8);
        for (int i = 0; i < 8; i++) begin
            chk("rr_byte", out_log[i], 32'(8'h10 + (i % 4)));
            chk("rr_gid", gid_log[i], 32'(i % 4));
        end

        // Single byte from requester 2.
        base = n_out; r2 = rdy_cnt[2];
        push(2, 1'b1, 8'h5A);
        drain("drain_single", 100);
        chk("single_count", n_out, base + 1);
        chk("single_byte", out_log[base], 8'h5A);
        chk("single_gid", gid_log[base], 2);
        chk("single_ready", rdy_cnt[2], r2 + 1);
        chk("single_gv", grant_valid, 0);
        chk("single_gid_hold", grant_id, 2);

        // Packet lock: requester 1 sends 3 bytes while requester 0 waits.
        push(0, 1'b1, 8'h20);
        drain("drain_pre_lock", 100);
        base = n_out;
        push(1, 1'b0, 8'h21); push(1, 1'b0, 8'h22); push(1, 1'b1, 8'h23);
        push(0, 1'b1, 8'h24);
        drain("drain_lock", 300);
        chk("lock_count", n_out, base + 4);
        for (int i = 0; i < 4; i++) chk("lock_byte", out_log[base + i], 32'(8'h21 + i));

        // Lock timeout: requester 3 stops after a non-last byte.
        base = n_out;
        push(3, 1'b0, 8'h33);
        wait_out("to_strobe", base + 1, 50);
        push(0, 1'b1, 8'h44); push(1, 1'b1, 8'h55);
        drain("drain_to", 300);
        chk("to_pulses", n_to, 1);
        chk("to_delay", to_delta, 17);
        chk("to_byte0", out_log[base], 8'h33);
        chk("to_byte1", out_log[base + 1], 8'h44);
        chk("to_byte2", out_log[base + 2], 8'h55);
        chk("to_next_gid", gid_log[base + 1], 0);

        // No acknowledge: the controller keeps ready high.
        noack = 1'b1;
        base = n_out;
        push(2, 1'b1, 8'h66);
        wait_out("noack_strobe", base + 1, 50);
        tick(8);
        chk("noack_err_pulses", n_err, 1);
        chk("noack_err_delay", err_delta, 4);
        chk("noack_count", n_out, base + 1);
        chk("noack_gv", grant_valid, 0);
        noack = 1'b0;
        tick(2);

        // Reset during WAIT_DONE of a 2-byte packet.
        base = n_out; r2 = rdy_cnt[2];
        push(2, 1'b0, 8'h77); push(2, 1'b1, 8'h78);
        wait_out("mid_strobe", base + 1, 50);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_en", ser_out_en, 0);
        chk("mid_rst_data", ser_data_out, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_gid", grant_id, 0);
        chk("mid_rst_gv", grant_valid, 0);
        chk("mid_rst_to", lock_timeout, 0);
        chk("mid_rst_err", ser_err, 0);
        tick(1);
        tail[2] = head[2];
        rst = 1'b0;
        tick(12);
        chk("mid_count", n_out, base + 1);
        chk("mid_byte", out_log[base], 8'h77);
        chk("mid_ready", rdy_cnt[2], r2 + 1);
        chk("pulse_shape", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_tx_arb.md
SERIAL_TX_ARB -- requirements
Module: serial_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the serial transmitter; legal range 2..8.
REQ-002 Parameter LOCK_TIMEOUT, default 1024: idle cycles after which a locked grant is forcibly released.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  bit i high = requester i presents a byte.
REQ-006 req_data  input  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  bit i high = presented byte ends requester i's packet.
REQ-008 req_ready  output  NUM_REQ  one-cycle pulse on bit i = requester i's byte consumed.
REQ-009 ser_data_out  output  8  byte to serial controller.
REQ-010 ser_out_en  output  1  one-cycle transmit strobe to serial controller.
REQ-011 ser_out_rdy  input  1  serial controller idle/ready; drops the cycle after a strobe is sampled, rises at end of stop bit.
REQ-012 grant_id  output  3  index of currently granted requester.
REQ-013 grant_valid  output  1  high while a requester holds the grant.
REQ-014 lock_timeout  output  1  one-cycle pulse when a grant is released by timeout.
REQ-015 ser_err  output  1  one-cycle pulse when serial controller fails to acknowledge a strobe.

Function
REQ-016 States SHALL be ARB, SEND, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-017 ARB: if any req_valid set, grant the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap; load grant_id, set grant_valid, go SEND; else stay, grant_valid 0.
REQ-018 SEND: when ser_out_rdy=1 and req_valid[grant_id]=1, on that edge register ser_data_out=req_data[grant_id], ser_out_en=1, req_ready[grant_id]=1, capture req_last[grant_id], go WAIT_BUSY.
REQ-019 ser_out_en and req_ready SHALL be high for exactly one cycle per byte; all other req_ready bits 0.
REQ-020 Requester i SHALL hold data/last stable until it sees req_ready[i]=1 and may change them in that cycle.
REQ-021 WAIT_BUSY: go WAIT_DONE when ser_out_rdy=0; if ser_out_rdy stays 1 for 4 cycles after the strobe, pulse ser_err, release grant, go ARB.
REQ-022 WAIT_DONE: on ser_out_rdy=1, if captured last=1 release grant (grant_valid 0, last_grant=grant_id), go ARB; else go SEND keeping the same grant (packet lock).
REQ-023 Lock: while in SEND, count consecutive cycles with req_valid[grant_id]=0; at LOCK_TIMEOUT pulse lock_timeout, release grant, update last_grant, go ARB; counter clears on any valid cycle and on state exit.
REQ-024 Requests from non-granted requesters SHALL never be served or acknowledged during a lock.
REQ-025 Minimum spacing between strobes SHALL be 3 cycles; no second strobe before ser_out_rdy has fallen and risen.
REQ-026 Simultaneous valid on all requesters: strict rotation, each served one packet in round-robin order.
REQ-027 grant_id SHALL keep its last value when grant_valid=0.

Reset
REQ-028 rst=1 at a clock edge SHALL force state ARB, ser_out_en 0, ser_data_out 0x00, req_ready 0, grant_id 0, grant_valid 0, lock_timeout 0, ser_err 0, lock counter 0, last_grant NUM_REQ-1 (requester 0 has first priority).
REQ-029 Reset mid-packet or mid-byte SHALL abandon the packet with no further strobe or req_ready pulse.

Verification
REQ-030 Single byte: req_valid[2]=1, data 0x5A, last 1, model rdy -> one ser_out_en with 0x5A, one req_ready[2] pulse, grant released after rdy returns.
REQ-031 Contention: all four valid, each 1-byte packets 0x10..0x13 -> transmit order 0x10,0x11,0x12,0x13, then 0x10 again if re-requested.
REQ-032 Lock: req 1 sends 3-byte packet (last on third) while req 0 valid -> bytes of req 1 contiguous, req 0 served only afterwards.
REQ-033 Timeout: LOCK_TIMEOUT=16, req 3 sends non-last byte then drops valid -> lock_timeout pulse exactly 16 cycles into SEND, next requester granted.
REQ-034 No ack: hold ser_out_rdy=1 permanently after strobe -> ser_err pulse 4 cycles after strobe, state ARB.
REQ-035 Reset mid-packet: assert rst during WAIT_DONE of a 2-byte packet -> all outputs at reset values next cycle, no strobe for the second byte.
